// File: rtl/pc_sequencer.sv
// picoMIPS instruction sequencer: fetch/execute FSM driving PC increment/load and register write strobes.
// Optional single-step gating of FETCH -> EXEC is enabled by defining PC_STEP_EN.
module pc_sequencer #(
  parameter int Psize = 6,
  parameter int Csize = 16
) (
  input  logic             clk,
  input  logic             reset,
`ifdef PC_STEP_EN
  input  logic             step,
`endif
  input  logic [Psize-1:0] pc_cur,
  input  logic             op_halt,
  input  logic             op_wait,
  input  logic             op_jmp,
  input  logic             op_beq,
  input  logic             op_wr,
  input  logic             zero,
  input  logic [Psize-1:0] imm,
  input  logic             in_valid,
  output logic             in_ack,
  output logic             pc_incr,
  output logic             pc_load,
  output logic [Psize-1:0] pc_target,
  output logic             reg_we,
  output logic             halted,
  output logic [Csize-1:0] retired
);

  localparam logic [1:0] FETCH = 2'd0;
  localparam logic [1:0] EXEC  = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] HALT  = 2'd3;

  logic [1:0]       state_reg;
  logic [1:0]       state_next;
  logic             incr_next;
  logic             load_next;
  logic             we_next;
  logic             ack_next;
  logic [Psize-1:0] target_next;
  logic [Csize-1:0] retired_next;
  logic             advance;

`ifdef PC_STEP_EN
  assign advance = step;
`else
  assign advance = 1'b1;
`endif

  always_comb begin
    state_next  = state_reg;
    incr_next   = 1'b0;
    load_next   = 1'b0;
    we_next     = 1'b0;
    ack_next    = 1'b0;
    target_next = pc_target;
    case (state_reg)
      FETCH: begin
        if (advance) state_next = EXEC;
      end
      EXEC: begin
        if (op_halt) begin
          state_next = HALT;
        end else if (op_wait) begin
          if (in_valid) begin
            ack_next   = 1'b1;
            incr_next  = 1'b1;
            we_next    = 1'b1;
            state_next = FETCH;
          end else begin
            state_next = WAIT;
          end
        end else if (op_jmp) begin
          load_next   = 1'b1;
          target_next = imm;
          state_next  = FETCH;
        end else if (op_beq && zero) begin
          // Same-width add: sign extension of imm is implicit modulo 2^Psize.
          load_next   = 1'b1;
          target_next = pc_cur + imm;
          state_next  = FETCH;
        end else begin
          incr_next  = 1'b1;
          we_next    = op_wr;
          state_next = FETCH;
        end
      end
      WAIT: begin
        if (in_valid) begin
          ack_next   = 1'b1;
          incr_next  = 1'b1;
          we_next    = 1'b1;
          state_next = FETCH;
        end
      end
      HALT: begin
        state_next = HALT;
      end
      default: begin
        state_next = FETCH;
      end
    endcase
  end

  // Count the strobe in the same edge that registers it; hold at all-ones.
  always_comb begin
    retired_next = retired;
    if ((incr_next || load_next) && (retired != {Csize{1'b1}}))
      retired_next = retired + Csize'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= FETCH;
      pc_incr   <= 1'b0;
      pc_load   <= 1'b0;
      reg_we    <= 1'b0;
      in_ack    <= 1'b0;
      halted    <= 1'b0;
      pc_target <= '0;
      retired   <= '0;
    end else begin
      state_reg <= state_next;
      pc_incr   <= incr_next;
      pc_load   <= load_next;
      reg_we    <= we_next;
      in_ack    <= ack_next;
      halted    <= (state_next == HALT);
      pc_target <= target_next;
      retired   <= retired_next;
    end
  end

endmodule
